data_ram_wait: RTL
==================

// Module: data_ram_wait
// PURPOSE
//  Word-addressed data RAM inside openmips_min_sopc, next to the core's MEM stage.
//  Serves loads/stores with a programmable number of wait states.
//  Raises stallreq_o so ctrl freezes the pipeline until the access is acknowledged.
//  Byte lanes are big-endian: sel[3] <-> data[31:24] ... sel[0] <-> data[7:0].
// PARAMETERS
//  ADDR_WIDTH   10  log2(number of 32-bit words); byte address bits [ADDR_WIDTH+1:2] used
//  WAIT_CYCLES  2   cycles spent in WAIT before commit; 0..15 legal
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset (`RstEnable = 1'b1)
//  mem_ce_i     in   1   access request from MEM stage, held while stalled
//  mem_we_i     in   1   1 = store, 0 = load
//  mem_addr_i   in   32  byte address; [1:0] and bits above ADDR_WIDTH+1 ignored (wrap)
//  mem_sel_i    in   4   byte-lane enables for stores; ignored for loads
//  mem_data_i   in   32  store data
//  mem_data_o   out  32  load data, full word, registered
//  mem_ack_o    out  1   one-cycle pulse: access complete
//  stallreq_o   out  1   to ctrl: hold pipeline
// BEHAVIOUR
//  Reset: state=IDLE, mem_ack_o=0, mem_data_o=0, counter=0; RAM contents NOT cleared.
//  FSM states IDLE, WAIT, ACK:
//   IDLE: if mem_ce_i=1, latch we/addr/sel/data. Load counter=WAIT_CYCLES.
//         Go to WAIT, or to ACK if WAIT_CYCLES=0.
//   WAIT: if mem_ce_i=0 (flush), abort: go to IDLE with no write and no ack.
//         Else decrement the counter. When counter==1, go to ACK on this edge (commit edge).
//   ACK : mem_ack_o=1 for exactly this cycle. Then go to IDLE unconditionally.
//  Commit edge = the edge entering ACK.
//   Store: write the latched data to each lane whose sel bit=1; other lanes unchanged.
//   Load: mem_data_o <= RAM[word addr].
//  mem_data_o holds the last load value until the next load commits; stores do not change it.
//  stallreq_o = mem_ce_i && (state != ACK); combinational.
//   It is low during ACK so the pipeline advances on the edge ending ACK.
//  Latency: a request first seen in cycle N acks in cycle N+WAIT_CYCLES+1.
//  Back-to-back: ce high in the cycle after ACK is a new request accepted from IDLE; no dead cycle.
//  Store with sel=4'b0000: completes normally (ack pulses), RAM unchanged.
//  Latched request fields are fixed for the whole access; input changes in WAIT are ignored.
//  Reset mid-WAIT: the pending store is discarded (not committed). All outputs take reset values next cycle.
//  Read-after-write to the same address returns the new data (the write commits before the read is accepted).
// TESTING
//  1 rst=1 for 3 cycles -> ack=0, data_o=0, stallreq=ce, state IDLE.
//  2 store 0x12345678 @0x40 sel=F, then load @0x40 -> ack in cycle N+3 each, data_o=0x12345678, stallreq high 3 cycles per access.
//  3 store 0x0000AB00 @0x40 sel=4'b0010, load @0x40 -> 0x1234AB78.
//  4 WAIT_CYCLES=0: ce held across 3 loads @0x0,0x4,0x8 -> ack every 2nd cycle, correct words.
//  5 store @0x80 then drop ce in WAIT -> no ack, later load @0x80 returns old value. Repeat with rst=1 in WAIT -> same result.
//  6 ADDR_WIDTH=10: store 0xDEADBEEF @0x1000, load @0x0 -> 0xDEADBEEF (wrap); load @0x3 -> same word.

Source files
------------

// File: rtl/data_ram_wait_if.sv
// Bus between the MEM stage (master) and the wait-state data RAM (slave).
// Signal names keep the RAM-side port names so both ends read alike.
interface data_ram_wait_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        stallreq_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, stallreq_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, stallreq_o
  );
endinterface

// File: rtl/data_ram_wait.sv
// Word-addressed data RAM with a programmable number of wait states per access.
// Holds the pipeline via stallreq_o until the one-cycle ack pulse.
module data_ram_wait #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_ram_wait_if.slave  bus
);
  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            sel;
    logic [31:0]           data;
  } req_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  req_t        req_in;
  req_t        cmt_req;
  logic        commit;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH];

  // Byte-offset bits and address bits above the RAM size are dropped, so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr_i[31:ADDR_WIDTH+2], bus.mem_addr_i[1:0]};

  assign req_in = '{we:   bus.mem_we_i,
                    addr: bus.mem_addr_i[ADDR_WIDTH+1:2],
                    sel:  bus.mem_sel_i,
                    data: bus.mem_data_i};

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cmt_req = req_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_ce_i) begin
          req_d = req_in;
          cnt_d = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the accept edge is also the commit edge.
            state_d = S_ACK;
            commit  = 1'b1;
            cmt_req = req_in;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.mem_ce_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      if (commit && !cmt_req.we) rdata_q <= mem_q[cmt_req.addr];
    end
  end

  // NOTE: the array has no reset; a reset only blocks the commit, contents survive.
  always_ff @(posedge clk) begin
    if (!rst && commit && cmt_req.we) begin
      for (int i = 0; i < 4; i++) begin
        if (cmt_req.sel[i]) mem_q[cmt_req.addr][8*i +: 8] <= cmt_req.data[8*i +: 8];
      end
    end
  end

  assign bus.mem_data_o = rdata_q;
  assign bus.mem_ack_o  = (state_q == S_ACK);
  assign bus.stallreq_o = bus.mem_ce_i && (state_q != S_ACK);
endmodule
